// File: rtl/express_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : express_dispatch                                          |
// | Function : Trip dispatcher for the floor 1 <-> floor 10 express car. |
// |            Handles calls, master-code programming, the permission    |
// |            handshake and floor tracking from car move acks.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module express_dispatch #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int STALL_LIMIT   = 8,
  parameter int AUTH_TIMEOUT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        call_top,
  input  logic        call_bottom,
  input  logic [13:0] keypad_code,
  input  logic        program_code,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        secure,
  input  logic        reject,
  input  logic        maintenance_request,
  output logic [3:0]  floor,
  output logic        destination,
  output logic [13:0] input_code,
  output logic        check_permission,
  output logic        update_enable,
  output logic        busy,
  output logic        arrived,
  output logic        denied,
  output logic        fault
);

  localparam int c_STEP_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int c_STALL_W = (STALL_LIMIT   > 1) ? $clog2(STALL_LIMIT)   : 1;
  localparam int c_AUTH_W  = (AUTH_TIMEOUT  > 1) ? $clog2(AUTH_TIMEOUT)  : 1;
  localparam logic [3:0] c_FLOOR_TOP = 4'd10;
  localparam logic [3:0] c_FLOOR_BOT = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WAIT_AUTH = 3'd2,
    S_TRAVEL    = 3'd3,
    S_ARRIVE    = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           floor_q, floor_d;
  logic                 dest_q, dest_d;
  logic [13:0]          code_q, code_d;
  logic                 check_q, check_d;
  logic                 update_q, update_d;
  logic                 busy_q, busy_d;
  logic                 arrived_q, arrived_d;
  logic                 denied_q, denied_d;
  logic                 fault_q, fault_d;
  logic                 dir_up_q, dir_up_d;
  logic [c_STEP_W-1:0]  step_q, step_d;
  logic [c_STALL_W-1:0] stall_q, stall_d;
  logic [c_AUTH_W-1:0]  auth_q, auth_d;

  // Direction is the latched trip direction; car motion only says "moving".
  logic       moving;
  logic [3:0] floor_next;
  logic [3:0] floor_target;
  assign moving       = move_up | move_down;
  assign floor_next   = dir_up_q ? (floor_q + 4'd1) : (floor_q - 4'd1);
  assign floor_target = dir_up_q ? c_FLOOR_TOP : c_FLOOR_BOT;

  // Next-state and next-output computation for the dispatcher.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dest_d    = dest_q;
    code_d    = code_q;
    dir_up_d  = dir_up_q;
    step_d    = step_q;
    stall_d   = stall_q;
    auth_d    = auth_q;
    fault_d   = fault_q;
    check_d   = 1'b0;
    update_d  = 1'b0;
    arrived_d = 1'b0;
    denied_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (maintenance_request) begin
          state_d = S_IDLE;
        end else if (program_code) begin
          code_d   = keypad_code;
          update_d = 1'b1;
        end else if (call_bottom && (floor_q == c_FLOOR_TOP)) begin
          dir_up_d = 1'b0;
          dest_d   = 1'b1;
          step_d   = '0;
          stall_d  = '0;
          state_d  = S_TRAVEL;
        end else if (call_top && (floor_q == c_FLOOR_BOT)) begin
          code_d  = keypad_code;
          check_d = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        auth_d  = '0;
        state_d = S_WAIT_AUTH;
      end

      S_WAIT_AUTH: begin
        if (secure) begin
          dir_up_d = 1'b1;
          dest_d   = 1'b1;
          step_d   = '0;
          stall_d  = '0;
          state_d  = S_TRAVEL;
        end else if (reject || (auth_q == c_AUTH_W'(AUTH_TIMEOUT - 1))) begin
          denied_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          auth_d = auth_q + 1'b1;
        end
      end

      S_TRAVEL: begin
        if (moving) begin
          stall_d = '0;
          if (step_q == c_STEP_W'(TRAVEL_CYCLES - 1)) begin
            step_d  = '0;
            floor_d = floor_next;
            if (floor_next == floor_target) begin
              dest_d    = 1'b0;
              arrived_d = 1'b1;
              state_d   = S_ARRIVE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end else if (stall_q == c_STALL_W'(STALL_LIMIT - 1)) begin
          dest_d  = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      S_ARRIVE: begin
        state_d = S_IDLE;
      end

      S_FAULT: begin
        dest_d  = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) || maintenance_request;
  end

  // State and registered outputs; active-low synchronous reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      floor_q   <= c_FLOOR_BOT;
      dest_q    <= 1'b0;
      code_q    <= '0;
      check_q   <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      arrived_q <= 1'b0;
      denied_q  <= 1'b0;
      fault_q   <= 1'b0;
      dir_up_q  <= 1'b0;
      step_q    <= '0;
      stall_q   <= '0;
      auth_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dest_q    <= dest_d;
      code_q    <= code_d;
      check_q   <= check_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      arrived_q <= arrived_d;
      denied_q  <= denied_d;
      fault_q   <= fault_d;
      dir_up_q  <= dir_up_d;
      step_q    <= step_d;
      stall_q   <= stall_d;
      auth_q    <= auth_d;
    end
  end

  assign floor            = floor_q;
  assign destination      = dest_q;
  assign input_code       = code_q;
  assign check_permission = check_q;
  assign update_enable    = update_q;
  assign busy             = busy_q;
  assign arrived          = arrived_q;
  assign denied           = denied_q;
  assign fault            = fault_q;

endmodule
`default_nettype wire
